adc_spi_multi: RTL
==================

Name: adc_spi_multi

Overview:
- Parametrised successor to the single-channel 12-bit SPI ADC front end. Runs a multi-channel serial ADC (LTC1407-style dual-channel frame) from the system clock.
- Each `clockenable` pulse triggers one conversion frame. The block drives `adconv` and `sck`, deserialises `miso` for NUM_CH channels, and presents all samples together through a valid/accept handshake.
- It feeds the effects chain in place of the fixed `datos`/`ready` pair.

Parameters:
- DATA_W, 12: sample width per channel.
- NUM_CH, 2: channels per frame (1..4).
- SCK_DIV, 2: system clocks per `sck` half-period (>=1).
- LEAD_BITS, 2: dummy `sck` cycles before each channel's data field.
- TAIL_BITS, 2: dummy `sck` cycles after the last channel.

Ports:
- clock, input, 1: system clock, rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- clockenable, input, 1: conversion request strobe (sample rate); level-tolerant, see Behaviour.
- miso, input, 1: ADC serial data.
- adconv, output, 1: conversion start to ADC.
- sck, output, 1: serial clock to ADC.
- datos, output, NUM_CH*DATA_W: samples; channel 0 in the MS field.
- valid, output, 1: `datos` holds an unconsumed frame.
- accept, input, 1: consumer takes `datos` when `valid` and `accept` are both high.
- busy, output, 1: frame in progress.
- overrun, output, 1: one-cycle pulse when an unconsumed frame is overwritten.

Behaviour:
- Reset (async, immediate): state=IDLE; adconv=0, sck=0, datos=0, valid=0, busy=0, overrun=0; shift register and counters cleared. Reset mid-frame aborts the frame with no output.
- FRAME_LEN = NUM_CH*(LEAD_BITS+DATA_W)+TAIL_BITS `sck` cycles. Each `sck` cycle = 2*SCK_DIV clocks: low half, then high half.
- Start request: rising edge of `clockenable`, detected with a registered copy.
- IDLE: `sck`=0.
  - Start request -> CONV on the next edge; busy=1.
  - Requests while not IDLE are ignored. No queueing.
- CONV: `adconv`=1 for exactly one `sck` period (2*SCK_DIV clocks); `sck` toggles normally. Then `adconv`=0 -> SHIFT.
- SHIFT: bit counter 0..FRAME_LEN-1.
  - `miso` is sampled on the last clock of each `sck` high half, just before the falling edge.
  - Samples at field positions LEAD..LEAD+DATA_W-1 of each channel are shifted in MSB first. Lead and tail bits are discarded.
  - After bit FRAME_LEN-1 completes -> DONE.
- DONE (1 clock): load assembled word into `datos`; valid=1; busy=0; `sck`=0 -> IDLE.
  - A start request in DONE is dropped.
- Handshake:
  - `valid` and `datos` are held until accept=1 in a cycle with valid=1. `valid` clears on the next edge.
  - DONE while valid=1 and accept=0: `datos` overwritten, `valid` stays 1, `overrun`=1 for one cycle.
  - DONE and accept in the same cycle: old frame is consumed, new frame loaded, `valid` stays 1, no overrun.
- Latency: start edge to `valid` = 1 + 2*SCK_DIV*(1+FRAME_LEN) + 1 clocks.
- Width rules: sample counter width = clog2(FRAME_LEN+1); divider width = clog2(SCK_DIV+1). No arithmetic on data.

Optional Feature:
- Macro: ADC_TWOS_COMP_EN.
- Defined: each channel field's MSB is inverted at the DONE load, converting offset-binary to two's complement (0x800 -> 0x000, 0x000 -> 0x800).
- Undefined: raw ADC code passed unchanged.

Decomposition:
- Package adc_spi_pkg:
  - state enum {IDLE, CONV, SHIFT, DONE};
  - FRAME_LEN derivation function;
  - clog2 helper;
  - default parameter constants.
- Sub-module adc_sck_gen:
  - divider producing `sck`, `sample_stb` (last clock of high half) and `period_end` strobes;
  - `run` enable;
  - forced low when `run`=0.

Test Plan (DATA_W=12, NUM_CH=2, SCK_DIV=2, LEAD=2, TAIL=2, FRAME_LEN=30):
- Basic frame:
  - Stimulus: reset, then `clockenable` rising; ADC model serves ch0=0xA5C, ch1=0x3F1.
  - Required: adconv high 4 clocks; 30 `sck` cycles follow; datos=24'hA5C3F1, valid=1 after 126 clocks.
  - With ADC_TWOS_COMP_EN defined: datos=24'h25CBF1.
- Hold and accept:
  - Stimulus: accept=0 for 50 clocks, then a 1-clock accept.
  - Required: datos stable throughout; valid falls on the next edge.
- Overrun:
  - Stimulus: second frame (0x001, 0xFFF) completes with valid=1 and accept=0.
  - Required: datos=24'h001FFF; overrun pulses exactly 1 clock; valid stays 1.
  - Stimulus: repeat with accept=1 in the DONE cycle.
  - Required: no overrun; valid stays 1.
- Ignored request:
  - Stimulus: `clockenable` toggles during SHIFT.
  - Required: no restart; busy stays 1; frame data unaffected.
- Async reset mid-frame:
  - Stimulus: reset_n low at bit 15.
  - Required: sck, adconv, valid, busy and datos go to 0 immediately.
  - Stimulus: a subsequent start.
  - Required: a clean full frame.

Source files
------------

// File: rtl/adc_spi_pkg.sv
// Shared types, defaults and elaboration helpers for the multi-channel SPI ADC front end.
package adc_spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DATA_W_DEF    = 12;
    localparam int NUM_CH_DEF    = 2;
    localparam int SCK_DIV_DEF   = 2;
    localparam int LEAD_BITS_DEF = 2;
    localparam int TAIL_BITS_DEF = 2;

    // Number of sck cycles in the SHIFT phase of one frame.
    function automatic int frame_len(input int num_ch, input int lead_bits,
                                     input int data_w, input int tail_bits);
        return num_ch * (lead_bits + data_w) + tail_bits;
    endfunction

    // Ceiling log2, never below 1 so it can size a counter directly.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) width++;
        return width;
    endfunction

endpackage

// File: rtl/adc_sck_gen.sv
// Serial clock divider: sck low half then high half, each SCK_DIV clocks; idles low when run=0.
module adc_sck_gen
    import adc_spi_pkg::*;
#(
    parameter int SCK_DIV = SCK_DIV_DEF
) (
    input  logic clock,
    input  logic reset_n,
    input  logic run,
    output logic sck,
    output logic sample_stb,
    output logic period_end
);

    localparam int DIV_W = clog2(SCK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             half_end;

    assign half_end   = run && (div_cnt == DIV_LAST);
    // The last clock of the high half is also the last clock of the sck period.
    assign sample_stb = half_end && sck;
    assign period_end = half_end && sck;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            sck     <= 1'b0;
        end else if (!run) begin
            div_cnt <= '0;
            sck     <= 1'b0;
        end else if (half_end) begin
            div_cnt <= '0;
            sck     <= ~sck;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/adc_spi_multi.sv
// Multi-channel SPI ADC frame sequencer with valid/accept output and overrun flag.
// Build option ADC_TWOS_COMP_EN: invert each channel MSB at load (offset-binary -> two's complement).
module adc_spi_multi
    import adc_spi_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int NUM_CH    = NUM_CH_DEF,
    parameter int SCK_DIV   = SCK_DIV_DEF,
    parameter int LEAD_BITS = LEAD_BITS_DEF,
    parameter int TAIL_BITS = TAIL_BITS_DEF
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     clockenable,
    input  logic                     miso,
    output logic                     adconv,
    output logic                     sck,
    output logic [NUM_CH*DATA_W-1:0] datos,
    output logic                     valid,
    input  logic                     accept,
    output logic                     busy,
    output logic                     overrun
);

    localparam int FRAME_LEN = frame_len(NUM_CH, LEAD_BITS, DATA_W, TAIL_BITS);
    localparam int CNT_W     = clog2(FRAME_LEN + 1);
    localparam int WORD_W    = NUM_CH * DATA_W;
    localparam int FIELD_W   = LEAD_BITS + DATA_W;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

    state_t             state;
    logic               ce_q;
    logic               start;
    logic               run;
    logic               sample_stb;
    logic               period_end;
    logic               in_data;
    logic [CNT_W-1:0]   bit_cnt;
    logic [WORD_W-1:0]  shreg;
    logic [WORD_W-1:0]  load_word;

    assign start = clockenable && !ce_q;
    assign run   = (state == CONV) || (state == SHIFT);

    adc_sck_gen #(
        .SCK_DIV (SCK_DIV)
    ) u_sck_gen (
        .clock      (clock),
        .reset_n    (reset_n),
        .run        (run),
        .sck        (sck),
        .sample_stb (sample_stb),
        .period_end (period_end)
    );

    // Lead and tail positions are discarded; only each channel's data window shifts in.
    always_comb begin
        in_data = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if ((int'(bit_cnt) >= c * FIELD_W + LEAD_BITS) &&
                (int'(bit_cnt) <  c * FIELD_W + FIELD_W))
                in_data = 1'b1;
        end
    end

    always_comb begin
        load_word = shreg;
`ifdef ADC_TWOS_COMP_EN
        for (int c = 0; c < NUM_CH; c++)
            load_word[c*DATA_W + DATA_W - 1] = ~shreg[c*DATA_W + DATA_W - 1];
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            ce_q    <= 1'b0;
            adconv  <= 1'b0;
            busy    <= 1'b0;
            valid   <= 1'b0;
            overrun <= 1'b0;
            datos   <= '0;
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            ce_q    <= clockenable;
            overrun <= 1'b0;
            if (valid && accept)
                valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= CONV;
                        busy    <= 1'b1;
                        adconv  <= 1'b1;
                        bit_cnt <= '0;
                        shreg   <= '0;
                    end
                end
                CONV: begin
                    if (period_end) begin
                        adconv <= 1'b0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (sample_stb && in_data)
                        shreg <= {shreg[WORD_W-2:0], miso};
                    if (period_end) begin
                        if (bit_cnt == LAST_BIT)
                            state <= DONE;
                        else
                            bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                DONE: begin
                    // A same-cycle accept consumes the old frame, so the new one is not an overrun.
                    datos   <= load_word;
                    valid   <= 1'b1;
                    overrun <= valid && !accept;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
